// File: rtl/toggle_event_decoder_if.sv
// Event-side bus of the toggle event decoder: toggle line in, pulse/queue/status out.
// The master modport is the producer/consumer side; the slave modport is the decoder.
interface toggle_event_decoder_if #(
    parameter int CNT_W = 4,
    parameter int TOT_W = 16
);
    logic             tog_in;
    logic             ev_pulse;
    logic             ev_valid;
    logic             ev_ready;
    logic [CNT_W-1:0] pend_cnt;
    logic [TOT_W-1:0] total_cnt;
    logic             q_mirror;
    logic             ovf;
    logic             ovf_clr;

    modport master (
        output tog_in,
        output ev_ready,
        output ovf_clr,
        input  ev_pulse,
        input  ev_valid,
        input  pend_cnt,
        input  total_cnt,
        input  q_mirror,
        input  ovf
    );

    modport slave (
        input  tog_in,
        input  ev_ready,
        input  ovf_clr,
        output ev_pulse,
        output ev_valid,
        output pend_cnt,
        output total_cnt,
        output q_mirror,
        output ovf
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// Recovers one event per level change of tog_in, queues them behind valid/ready and counts them.
// Define TDEC_SYNC_EN to pass tog_in through a SYNC_STAGES-deep synchronizer instead of one sample flop.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    toggle_event_decoder_if.slave bus
);

`ifdef TDEC_SYNC_EN
    localparam int D = SYNC_STAGES;
`else
    localparam int D = 1;
`endif
    // Sized for the deeper of the two input-path options so either build fits.
    localparam int IW = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [IW-1:0]    init_cnt;
    logic [D-1:0]     sync_q;
    logic             p;
    logic             ev_pulse_q;
    logic             q_mirror_q;
    logic             ovf_q;
    logic [CNT_W-1:0] pend_q;
    logic [TOT_W-1:0] total_q;

    logic s;
    logic valid;
    logic accept;
    logic event_now;
    logic ovf_set;

    assign s         = sync_q[D-1];
    assign valid     = (pend_q != '0);
    assign accept    = valid & bus.ev_ready;
    assign event_now = (state == RUN) & (s ^ p);
    // An event arriving together with an accept leaves the count alone, so it can never be lost.
    assign ovf_set   = event_now & ~accept & (pend_q == PEND_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            init_cnt   <= '0;
            sync_q     <= '0;
            p          <= 1'b0;
            ev_pulse_q <= 1'b0;
            q_mirror_q <= 1'b0;
            ovf_q      <= 1'b0;
            pend_q     <= '0;
            total_q    <= '0;
        end else begin
`ifdef TDEC_SYNC_EN
            sync_q <= {sync_q[D-2:0], bus.tog_in};
`else
            sync_q <= bus.tog_in;
`endif
            p <= s;

            // INIT lasts D+1 edges so the chain and p settle before edges are trusted.
            if (state == INIT) begin
                if (init_cnt == IW'(D)) begin
                    state <= RUN;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end

            ev_pulse_q <= event_now;
            q_mirror_q <= (state == RUN) ? s : 1'b0;
            total_q    <= total_q + TOT_W'(event_now);

            if (event_now && !accept) begin
                if (pend_q != PEND_MAX) begin
                    pend_q <= pend_q + 1'b1;
                end
            end else if (!event_now && accept) begin
                pend_q <= pend_q - 1'b1;
            end

            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.ev_pulse  = ev_pulse_q;
    assign bus.ev_valid  = valid;
    assign bus.pend_cnt  = pend_q;
    assign bus.total_cnt = total_q;
    assign bus.q_mirror  = q_mirror_q;
    assign bus.ovf       = ovf_q;

endmodule
